// File: rtl/pll_seq_ctrl.sv
// PLL bring-up sequencer: PLL reset, filtered lock, staggered clock enables, downstream reset release.
// Define PLL_SEQ_LOSS_CNT_EN to add the loss_cnt output (saturating count of lock-loss restarts).
module pll_seq_ctrl #(
    parameter int PLL_RST_CYC = 100,
    parameter int LOCK_FILT   = 1024,
    parameter int LOCK_TMO    = 50000,
    parameter int EN_GAP      = 16,
    parameter int RST_HOLD    = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic [4:0] enclk,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int RST_W  = $clog2(PLL_RST_CYC + 2);
    localparam int TMO_W  = $clog2(LOCK_TMO + 2);
    localparam int FILT_W = $clog2(LOCK_FILT + 2);
    localparam int GAP_W  = $clog2(EN_GAP + 2);
    localparam int HOLD_W = $clog2(RST_HOLD + 2);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'((PLL_RST_CYC > 0) ? PLL_RST_CYC - 1 : 0);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((LOCK_TMO > 0) ? LOCK_TMO - 1 : 0);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'((LOCK_FILT > 0) ? LOCK_FILT - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((EN_GAP > 0) ? EN_GAP - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [2:0]        IDX_LAST  = 3'd4;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_FILTER,
        S_ENABLE,
        S_HOLD,
        S_RUN,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        sync_q;
    logic              lock_s;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [3:0]        retry_q, retry_d;
    logic [3:0]        retry_inc;

    logic              timeout;
    logic              loss_evt;
    logic              restart;

    logic              pll_reset_q, sys_rst_q, ready_q, fault_q;
    logic [4:0]        enclk_q;
    logic              pll_reset_d, sys_rst_d, ready_d, fault_d;
    logic [4:0]        enclk_d;
    logic [4:0]        en_mask_d;
    logic              en_on_d;

    assign lock_s    = sync_q[1];
    assign retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        filt_cnt_d = filt_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        timeout    = 1'b0;
        loss_evt   = 1'b0;
        restart    = 1'b0;

        if (relock_req) begin
            restart = 1'b1;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RST_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (tmo_cnt_q >= TMO_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        if (lock_s) begin
                            state_d    = S_FILTER;
                            filt_cnt_d = '0;
                        end
                    end
                end
                S_FILTER: begin
                    // A completed filter run wins over a timeout landing on the same cycle.
                    if (lock_s && (filt_cnt_q == FILT_LAST)) begin
                        state_d   = S_ENABLE;
                        gap_cnt_d = '0;
                        idx_d     = '0;
                    end else if (tmo_cnt_q >= TMO_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        if (!lock_s) begin
                            state_d    = S_WAIT_LOCK;
                            filt_cnt_d = '0;
                        end else begin
                            filt_cnt_d = filt_cnt_q + FILT_W'(1);
                        end
                    end
                end
                S_ENABLE: begin
                    if (!lock_s) begin
                        loss_evt = 1'b1;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d    = S_HOLD;
                            hold_cnt_d = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!lock_s) begin
                        loss_evt = 1'b1;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        loss_evt = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    restart = 1'b1;
                end
            endcase

            if (timeout) begin
                retry_d = retry_inc;
                if (retry_inc == RETRY_MAX) begin
                    state_d = S_FAULT;
                end else begin
                    restart = 1'b1;
                end
            end
            if (loss_evt) begin
                restart = 1'b1;
            end
        end

        if (restart) begin
            state_d    = S_PLL_RST;
            rst_cnt_d  = '0;
            tmo_cnt_d  = '0;
            filt_cnt_d = '0;
            gap_cnt_d  = '0;
            hold_cnt_d = '0;
            idx_d      = '0;
        end
    end

    // Enable bits are cumulative: every bit up to the current step index is on.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_en_mask
            assign en_mask_d[gi] = (idx_d >= 3'(gi));
        end
    endgenerate

    assign en_on_d     = (state_d == S_ENABLE) || (state_d == S_HOLD) || (state_d == S_RUN);
    assign enclk_d     = en_on_d ? en_mask_d : 5'b00000;
    assign pll_reset_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    assign sys_rst_d   = (state_d != S_RUN);
    assign ready_d     = (state_d == S_RUN);
    assign fault_d     = (state_d == S_FAULT);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= S_PLL_RST;
            sync_q      <= '0;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            filt_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            enclk_q     <= 5'b00000;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], lock};
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            enclk_q     <= enclk_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign enclk     = enclk_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    // loss_evt is only raised when no relock request is present, so a same-cycle relock is not counted.
    always_ff @(posedge clkin) begin
        if (reset) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl: cycle-level reference model plus directed scenarios with hand-derived timings.
module tb_pll_seq_ctrl;

    localparam int P_RST   = 4;
    localparam int P_FILT  = 8;
    localparam int P_TMO   = 20;
    localparam int P_GAP   = 2;
    localparam int P_HOLD  = 3;
    localparam int P_RETRY = 3;

    localparam int PH_PRST  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_FILT  = 2;
    localparam int PH_EN    = 3;
    localparam int PH_HOLD  = 4;
    localparam int PH_RUN   = 5;
    localparam int PH_FAULT = 6;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset;
    logic [4:0] enclk;
    logic       sys_rst;
    logic       ready;
    logic       fault;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #10 clkin = ~clkin;

    pll_seq_ctrl #(
        .PLL_RST_CYC(P_RST),
        .LOCK_FILT  (P_FILT),
        .LOCK_TMO   (P_TMO),
        .EN_GAP     (P_GAP),
        .RST_HOLD   (P_HOLD),
        .MAX_RETRY  (P_RETRY)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .lock      (lock),
        .relock_req(relock_req),
        .pll_reset (pll_reset),
        .enclk     (enclk),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt  (loss_cnt)
`endif
    );

    // Reference model: phase plus elapsed-time counts; outputs derived arithmetically.
    int ph = PH_PRST;
    int t = 0;        // cycles spent in PRST / EN / HOLD
    int tl = 0;       // cycles spent waiting for lock since the last PLL reset
    int hi = 0;       // lock-high run length inside the filter
    int retries = 0;
    int losses = 0;
    bit s1 = 1'b0, s2 = 1'b0, m_valid = 1'b0;

    task automatic m_restart();
        ph = PH_PRST; t = 0; tl = 0; hi = 0;
    endtask

    task automatic m_timeout();
        retries++;
        if (retries == P_RETRY) ph = PH_FAULT;
        else m_restart();
    endtask

    task automatic m_loss();
        m_restart();
        if (losses < 255) losses++;
    endtask

    always @(posedge clkin) begin : model
        bit ls;
        if (reset) begin
            m_restart();
            retries = 0; losses = 0; s1 = 1'b0; s2 = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls = s2; s2 = s1; s1 = lock;
            if (relock_req) begin
                m_restart();
                retries = 0;
            end else begin
                case (ph)
                    PH_PRST: if (t + 1 >= P_RST) begin ph = PH_WAIT; tl = 0; end else t++;
                    PH_WAIT: begin
                        if (tl + 1 >= P_TMO) m_timeout();
                        else begin
                            tl++;
                            if (ls) begin ph = PH_FILT; hi = 0; end
                        end
                    end
                    PH_FILT: begin
                        if (ls && hi + 1 >= P_FILT) begin ph = PH_EN; t = 0; end
                        else if (tl + 1 >= P_TMO) m_timeout();
                        else if (!ls) begin ph = PH_WAIT; hi = 0; tl++; end
                        else begin hi++; tl++; end
                    end
                    PH_EN: begin
                        if (!ls) m_loss();
                        else begin
                            t++;
                            if (t >= 5 * P_GAP) begin ph = PH_HOLD; t = 0; end
                        end
                    end
                    PH_HOLD: begin
                        if (!ls) m_loss();
                        else begin
                            t++;
                            if (t >= P_HOLD) begin ph = PH_RUN; retries = 0; end
                        end
                    end
                    PH_RUN: if (!ls) m_loss();
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [8:0] model_outputs();
        int m;
        logic [4:0] en;
        m = (1 << (t / P_GAP + 1)) - 1;
        if (ph == PH_EN) en = m[4:0];
        else if (ph == PH_HOLD || ph == PH_RUN) en = 5'b11111;
        else en = 5'b00000;
        return {(ph == PH_PRST || ph == PH_FAULT), en, (ph != PH_RUN), (ph == PH_RUN), (ph == PH_FAULT)};
    endfunction

    always @(negedge clkin) begin : compare
        logic [8:0] expv;
        if (m_valid) begin
            expv = model_outputs();
            checks++;
            if ({pll_reset, enclk, sys_rst, ready, fault} !== expv) begin
                errors++;
                $display("FAIL cycle %0d outputs {pll_reset,enclk,sys_rst,ready,fault}: got %b_%b_%b%b%b want %b_%b_%b%b%b",
                         cyc, pll_reset, enclk, sys_rst, ready, fault,
                         expv[8], expv[7:3], expv[2], expv[1], expv[0]);
            end
`ifdef PLL_SEQ_LOSS_CNT_EN
            checks++;
            if (loss_cnt !== 8'(losses)) begin
                errors++;
                $display("FAIL cycle %0d loss_cnt: got %0d want %0d", cyc, loss_cnt, losses);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clkin);
        @(negedge clkin);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk(name, ready, 1);
    endtask

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stim
        int k, n_hi, fall_sys, falls, c0;
        int rise[5];
        bit hi_done;
        logic prev;

        // Reset with lock already high, then the full bring-up.
        lock = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset pll_reset", pll_reset, 1);
        chk("reset enclk", enclk, 0);
        chk("reset sys_rst", sys_rst, 1);
        chk("reset ready", ready, 0);
        chk("reset fault", fault, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("reset loss_cnt", loss_cnt, 0);
`endif
        reset = 1'b0;
        for (int b = 0; b < 5; b++) rise[b] = -1;
        n_hi = 1;          // the cycle after the last reset edge is already the first PLL_RST cycle
        hi_done = 1'b0;
        fall_sys = -1;
        k = 0;
        while (ready !== 1'b1 && k < 100) begin
            tick();
            k++;
            if (!hi_done) begin
                if (pll_reset === 1'b1) n_hi++;
                else hi_done = 1'b1;
            end
            for (int b = 0; b < 5; b++) if (enclk[b] === 1'b1 && rise[b] < 0) rise[b] = k;
            if (sys_rst === 1'b0 && fall_sys < 0) fall_sys = k;
        end
        chk("pll_reset high cycles", n_hi, 4);
        chk("enclk[0] rise cycle", rise[0], 13);
        for (int b = 1; b < 5; b++) chk($sformatf("enclk[%0d] gap", b), rise[b] - rise[b-1], 2);
        chk("sys_rst fall after HOLD entry", fall_sys - (rise[4] + P_GAP), 3);
        chk("ready cycle", fall_sys, 26);
        chk("ready in RUN", ready, 1);

        // Lock loss while running.
        lock = 1'b0;
        k = 0;
        while (ready === 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk("lock loss latency", k, 3);
        chk("lock loss enclk", enclk, 0);
        chk("lock loss sys_rst", sys_rst, 1);
        chk("lock loss pll_reset", pll_reset, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("loss_cnt after loss", loss_cnt, 1);
`endif
        lock = 1'b1;
        wait_ready("ready after loss", 60);

        // Relock request coinciding with a lock loss.
        lock = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("relock+loss pll_reset", pll_reset, 1);
        chk("relock+loss ready", ready, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("relock+loss loss_cnt", loss_cnt, 1);
`endif
        lock = 1'b1;
        wait_ready("ready after relock", 60);

        // Single-cycle lock glitch after five filter cycles.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 8) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        while (enclk === 5'b00000 && cyc - c0 < 40) tick();
        chk("ENABLE entry after glitch", cyc - c0, 20);

        // Reset in the middle of ENABLE.
        k = 0;
        while (enclk !== 5'b00011 && k < 20) begin
            tick();
            k++;
        end
        chk("enclk before reset", enclk, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid-reset enclk", enclk, 0);
        chk("mid-reset pll_reset", pll_reset, 1);
        chk("mid-reset sys_rst", sys_rst, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("mid-reset loss_cnt", loss_cnt, 0);
`endif
        wait_ready("ready after mid reset", 60);

        // Lock never returns: retries exhaust into FAULT.
        lock = 1'b0;
        k = 0;
        falls = 0;
        prev = pll_reset;
        while (fault !== 1'b1 && k < 200) begin
            tick();
            k++;
            if (prev === 1'b1 && pll_reset === 1'b0) falls++;
            prev = pll_reset;
        end
        chk("fault cycle", k, 75);
        chk("PLL reset attempts", falls, 3);
        chk("fault pll_reset", pll_reset, 1);
        chk("fault enclk", enclk, 0);
        chk("fault sys_rst", sys_rst, 1);
        repeat (5) tick();
        chk("fault sticky", fault, 1);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("relock clears fault", fault, 0);
        chk("relock pll_reset", pll_reset, 1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
